pixel_readout_ctrl: RTL
=======================

Name: pixel_readout_ctrl

Overview:
Readout scheduler for the 2x2 pixel array and its shared column data bus.
- On a start request, runs the ADC conversion phase, generating the digital ramp code that drives the bus while the pixels latch.
- Then selects each row in turn, captures that row's column values, and streams pixels out over a valid/ready interface.
- Sits between the exposure FSM (which issues start after exposure) and the downstream frame buffer.

Parameters:
N_ROWS, 2, number of pixel rows; one-hot row selects
N_COLS, 2, pixels per row, i.e. column data buses
DATA_W, 8, pixel/ramp code width
C_CONVERT, 255, conversion cycles; must be 1..2**DATA_W
C_READ, 5, row-select settle cycles before capture; must be >= 1

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  frame readout request; sampled in IDLE only
abort  in  1  synchronous abort; returns to IDLE next cycle
convert  out  1  high during conversion phase
drive_bus  out  1  high when the ramp code drives the column buses (equals convert)
ramp_code  out  DATA_W  digital ramp value placed on the buses
read_row  out  N_ROWS  one-hot row select; all zero outside READ
col_data  in  N_COLS*DATA_W  column buses; column c occupies bits [c*DATA_W +: DATA_W]
pix_valid  out  1  output pixel valid
pix_ready  in  1  downstream accepts pixel
pix_data  out  DATA_W  pixel value
pix_row  out  clog2(N_ROWS)  row index of pix_data
pix_col  out  clog2(N_COLS)  column index of pix_data
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; all outputs 0; row buffer, counters and indices cleared.
- States: IDLE, CONVERT, READ, STREAM, DONE.
- IDLE:
  - start=1 at an edge -> CONVERT next cycle.
  - start is ignored in all other states; no queuing.
- CONVERT:
  - Lasts exactly C_CONVERT cycles; convert = drive_bus = 1.
  - ramp_code is 0 in the first cycle and increments by 1 each cycle, reaching C_CONVERT-1 in the last cycle; no wrap is possible.
  - ramp_code returns to 0 on exit.
  - Exit -> READ with row = 0.
- READ:
  - read_row[row] = 1 for exactly C_READ cycles.
  - On the edge ending the last READ cycle, all N_COLS values from col_data are registered into the row buffer.
  - -> STREAM with col = 0; read_row deasserts on the same edge.
- STREAM:
  - pix_valid = 1; pix_data = buffer[col]; pix_row = row; pix_col = col.
  - pix_data/row/col are held stable while pix_valid & !pix_ready.
  - Transfer occurs when pix_valid & pix_ready at an edge; col increments; one pixel per cycle maximum.
  - After col = N_COLS-1 transfers: if row < N_ROWS-1, row++ and -> READ; otherwise -> DONE.
  - pix_valid drops in the cycle after the final column transfer.
- DONE: one cycle; frame_done = 1, busy = 1; -> IDLE.
- abort=1 in any non-IDLE state:
  - -> IDLE at the next edge; convert, read_row and pix_valid are 0 from that edge.
  - No frame_done pulse.
  - abort has priority over every other transition.
  - In IDLE, abort has no effect; start is not accepted when abort=1.
- Frame length with pix_ready held 1: C_CONVERT + N_ROWS*(C_READ+N_COLS) + 1 busy cycles. With defaults this is 270.

Optional Feature:
TEST_PATTERN_EN
- Defined: the READ capture stores pattern values instead of col_data, where value = (row*N_COLS + col) truncated to DATA_W. Timing and read_row behaviour are unchanged.
- Undefined: col_data is captured as specified above.

Decomposition:
- Package pixel_readout_pkg holds:
  - state enum typedef readout_state_t
  - localparam helpers ROW_W = clog2(N_ROWS) and COL_W = clog2(N_COLS)
  - default timing constants
- One natural sub-module, phase_counter: a loadable down-counter with terminal-count output, used for both the CONVERT and READ durations.

Test Plan:
1. Reset, then start pulse, pix_ready=1, default parameters -> convert high 255 cycles with ramp_code 0..254; busy high 270 cycles; frame_done pulses once.
2. Columns driven as row0 {0x11,0x22}, row1 {0x33,0x44} during the respective read_row -> stream (0,0)0x11, (0,1)0x22, (1,0)0x33, (1,1)0x44 in that order.
3. pix_ready low for 3 cycles mid-STREAM -> pix_valid stays 1 and pix_data/row/col are unchanged; no pixel lost or duplicated.
4. start re-asserted during CONVERT and during STREAM -> ignored; exactly one frame produced.
5. abort at CONVERT cycle 100, then separately reset_n low during READ -> IDLE with convert=0, read_row=0, no frame_done. For the reset case, all outputs go to 0 immediately without waiting for an edge.
6. TEST_PATTERN_EN defined, col_data all 0xFF -> streamed values 0, 1, 2, 3.

Source files
------------

// File: rtl/pixel_readout_pkg.sv
// Shared types and default timing for the pixel array readout scheduler.
package pixel_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_READ,
    ST_STREAM,
    ST_DONE
  } readout_state_t;

  localparam int DEF_N_ROWS    = 2;
  localparam int DEF_N_COLS    = 2;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_C_CONVERT = 255;
  localparam int DEF_C_READ    = 5;

  // Index width that never collapses to zero bits for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W = idx_w(DEF_N_ROWS);
  localparam int COL_W = idx_w(DEF_N_COLS);

endpackage

// File: rtl/pixel_readout_ctrl_phase_counter.sv
// Loadable down-counter; tc_o flags the final cycle of a timed phase.
module phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == '0);

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Frame readout scheduler: ramp conversion, row-by-row capture, pixel streaming.
// Build option TEST_PATTERN_EN replaces captured column data with (row*N_COLS + col).
module pixel_readout_ctrl
  import pixel_readout_pkg::*;
#(
  parameter int N_ROWS    = DEF_N_ROWS,
  parameter int N_COLS    = DEF_N_COLS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int C_CONVERT = DEF_C_CONVERT,
  parameter int C_READ    = DEF_C_READ,
  localparam int ROW_BITS = idx_w(N_ROWS),
  localparam int COL_BITS = idx_w(N_COLS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     convert,
  output logic                     drive_bus,
  output logic [DATA_W-1:0]        ramp_code,
  output logic [N_ROWS-1:0]        read_row,
  input  logic [N_COLS*DATA_W-1:0] col_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [DATA_W-1:0]        pix_data,
  output logic [ROW_BITS-1:0]      pix_row,
  output logic [COL_BITS-1:0]      pix_col,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int MAX_CNT = (C_CONVERT > C_READ) ? C_CONVERT : C_READ;
  localparam int CNT_W   = idx_w(MAX_CNT);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(C_CONVERT - 1);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(C_READ - 1);

  readout_state_t      state_q, state_d;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;
  logic [DATA_W-1:0]   row_buf_q [N_COLS];

  logic             cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt_load_val, cnt;
  logic             last_col, last_row, aborting;

  assign last_col = (col_q == COL_BITS'(N_COLS - 1));
  assign last_row = (row_q == ROW_BITS'(N_ROWS - 1));
  assign aborting = abort && (state_q != ST_IDLE);

  phase_counter #(.W(CNT_W)) u_phase_cnt (
    .clk       (clk),
    .rst_n     (reset_n),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .en_i      (cnt_en),
    .count_o   (cnt),
    .tc_o      (cnt_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (aborting) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (start && !abort) state_d = ST_CONVERT;
        ST_CONVERT: if (cnt_tc) state_d = ST_READ;
        ST_READ:    if (cnt_tc) state_d = ST_STREAM;
        ST_STREAM:  if (pix_ready && last_col) state_d = last_row ? ST_DONE : ST_READ;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // The counter is reloaded on entry to each timed phase and counts down to its last cycle.
  always_comb begin
    cnt_load     = (state_d != state_q) && (state_d == ST_CONVERT || state_d == ST_READ);
    cnt_load_val = (state_d == ST_CONVERT) ? CONV_LAST : READ_LAST;
    cnt_en       = (state_q == ST_CONVERT) || (state_q == ST_READ);
  end

  // NOTE: the row buffer is tiny and must read as zero after reset, so it is reset explicitly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q <= '0;
      col_q <= '0;
      for (int c = 0; c < N_COLS; c++) row_buf_q[c] <= '0;
    end else if (aborting || state_q == ST_IDLE) begin
      row_q <= '0;
      col_q <= '0;
    end else if (state_q == ST_READ && cnt_tc) begin
      col_q <= '0;
      for (int c = 0; c < N_COLS; c++) begin
`ifdef TEST_PATTERN_EN
        row_buf_q[c] <= DATA_W'(int'(row_q) * N_COLS + c);
`else
        row_buf_q[c] <= col_data[c*DATA_W +: DATA_W];
`endif
      end
    end else if (state_q == ST_STREAM && pix_ready) begin
      if (last_col) begin
        col_q <= '0;
        if (!last_row) row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  always_comb begin
    convert    = 1'b0;
    ramp_code  = '0;
    read_row   = '0;
    pix_valid  = 1'b0;
    pix_data   = '0;
    pix_row    = '0;
    pix_col    = '0;
    busy       = (state_q != ST_IDLE);
    frame_done = 1'b0;
    case (state_q)
      ST_CONVERT: begin
        convert   = 1'b1;
        ramp_code = DATA_W'(CONV_LAST - cnt);
      end
      ST_READ:   read_row[row_q] = 1'b1;
      ST_STREAM: begin
        pix_valid = 1'b1;
        pix_data  = row_buf_q[col_q];
        pix_row   = row_q;
        pix_col   = col_q;
      end
      ST_DONE:   frame_done = 1'b1;
      default:   ;
    endcase
  end

  assign drive_bus = convert;

endmodule
